// File: rtl/dac_spi_tx.sv
// SPI transmitter for a 12-bit DAC: a small sample FIFO feeding a 16-bit frame serialiser (SPI mode 0).
// Optional per-frame load strobe ldac_n is built when DAC_LDAC_EN is defined.
module dac_spi_tx #(
  parameter int         DATA_W     = 12,
  parameter logic [3:0] CTRL_WORD  = 4'b0011,
  parameter int         CLK_DIV    = 2,
  parameter int         FIFO_DEPTH = 4,
  parameter int         CS_GAP     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  output logic              busy,
  output logic              overflow,
`ifdef DAC_LDAC_EN
  output logic              ldac_n,
`endif
  output logic [1:0]        state_dbg
);

  localparam int FRAME_W = 4 + DATA_W;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int DIV_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(CS_GAP - 1);
  localparam logic [4:0]       BIT_LAST = 5'(FRAME_W - 1);
  localparam logic [AW:0]      DEPTH_L  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Handshake: a sample is accepted on any clk edge where sample_valid && sample_ready;
  // sample_ready depends only on FIFO fullness, never on sample_valid.

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [4:0]           bit_q, bit_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 mosi_q, mosi_d;
  logic                 ovf_q, ovf_d;
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]    fifo_mem_q [FIFO_DEPTH];
  logic                 full, empty, push, pop;
`ifdef DAC_LDAC_EN
  logic                 ldac_n_q, ldac_n_d;
`endif

  assign full         = (wr_ptr_q - rd_ptr_q) == DEPTH_L;
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign push         = sample_valid && !full;
  assign sample_ready = !full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (sample_valid && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= sample_in;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    pop     = 1'b0;
`ifdef DAC_LDAC_EN
    ldac_n_d = 1'b1;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = {CTRL_WORD, fifo_mem_q[rd_ptr_q[AW-1:0]]};
          mosi_d  = CTRL_WORD[3];
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          bit_d   = '0;
          div_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = !sclk_q;
          // Falling sclk edge: present the next bit, or close the frame after the last one.
          if (sclk_q) begin
            if (bit_q == BIT_LAST) begin
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              state_d = ST_GAP;
            end else begin
              shreg_d = shreg_q << 1;
              mosi_d  = shreg_q[FRAME_W-2];
              bit_d   = bit_q + 5'd1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (div_q == GAP_LAST) begin
          div_d   = '0;
          state_d = ST_IDLE;
`ifdef DAC_LDAC_EN
          ldac_n_d = 1'b0;
`endif
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef DAC_LDAC_EN
      ldac_n_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef DAC_LDAC_EN
      ldac_n_q <= ldac_n_d;
`endif
    end
  end

  assign cs_n      = cs_n_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign busy      = (state_q != ST_IDLE);
  assign overflow  = ovf_q;
  assign state_dbg = state_q;
`ifdef DAC_LDAC_EN
  assign ldac_n    = ldac_n_q;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: randomized and directed samples against a cycle-level occupancy/scheduling
// model; a monitor reassembles SPI frames and checks them against an expected-frame queue.
module tb_dac_spi_tx;

  localparam int CLK_DIV    = 2;
  localparam int CS_GAP     = 2;
  localparam int DEPTH      = 4;
  localparam int FRAME_CYC  = 32 * CLK_DIV;
  localparam int PERIOD     = FRAME_CYC + CS_GAP + 1;
  localparam logic [3:0] CTRL = 4'b0011;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic        sample_ready, cs_n, sclk, mosi, busy, overflow;
  logic [1:0]  state_dbg;
`ifdef DAC_LDAC_EN
  logic        ldac_n;
`endif

  dac_spi_tx #(.DATA_W(12), .CTRL_WORD(CTRL), .CLK_DIV(CLK_DIV),
               .FIFO_DEPTH(DEPTH), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .busy(busy), .overflow(overflow),
`ifdef DAC_LDAC_EN
    .ldac_n(ldac_n),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = !clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // reference model: FIFO contents, earliest edge at which the next frame may start
  logic [11:0] m_q[$];
  logic [15:0] exp_q[$];
  int          exp_t_q[$];
  int          next_pop;
  int          last_pop;
  logic        m_ovf;

  function automatic logic m_busy();
    return (cyc >= last_pop) && (cyc < last_pop + FRAME_CYC + CS_GAP);
  endfunction

  // driver: called at a negedge; checks this cycle's outputs, drives inputs, advances the model
  task automatic step(input logic v, input logic [11:0] d);
    int e;
    chk("sample_ready", sample_ready, m_q.size() < DEPTH);
    chk("busy", busy, m_busy());
    chk("overflow", overflow, m_ovf);
`ifdef DAC_LDAC_EN
    chk("ldac_n", ldac_n, !(cyc == last_pop + FRAME_CYC + CS_GAP));
`endif
    sample_valid = v;
    sample_in    = d;
    e = cyc + 1;
    if (m_q.size() > 0 && e >= next_pop) begin
      exp_q.push_back({CTRL, m_q[0]});
      exp_t_q.push_back(e);
      void'(m_q.pop_front());
      last_pop = e;
      next_pop = e + PERIOD;
    end else if (v && m_q.size() < DEPTH) begin
      m_q.push_back(d);
      v = 1'b0;
    end
    if (v) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 12'h000);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sample_valid = 1'b0;
    m_q.delete();
    exp_q.delete();
    exp_t_q.delete();
    next_pop = 0;
    last_pop = -100000;
    m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_ready", sample_ready, 1'b1);
`ifdef DAC_LDAC_EN
    chk("rst_ldac_n", ldac_n, 1'b1);
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // monitor / scoreboard: reassembles frames from mosi at each sclk rise
  logic        in_frame = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        have_rise = 1'b0;
  logic [15:0] bits;
  int          nbits, low_cnt, fall_edge, rise_edge;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      in_frame  = 1'b0;
      have_rise = 1'b0;
    end else begin
      if (cs_n) chk("sclk_idle_low", sclk, 1'b0);
      if (!in_frame && cs_n == 1'b0) begin
        in_frame  = 1'b1;
        bits      = '0;
        nbits     = 0;
        low_cnt   = 0;
        fall_edge = cyc;
        if (have_rise) chk("cs_gap_min", (cyc - rise_edge) >= CS_GAP + 1, 1'b1);
      end
      if (in_frame) begin
        if (cs_n == 1'b0) begin
          low_cnt++;
          if (sclk && !prev_sclk) begin
            bits = {bits[14:0], mosi};
            nbits++;
          end
        end else begin
          in_frame  = 1'b0;
          have_rise = 1'b1;
          rise_edge = cyc;
          chk("frame_bits", nbits, 16);
          chk("frame_len", low_cnt, FRAME_CYC);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", bits, 32'hDEAD_BEEF);
          end else begin
            chk("frame_data", bits, exp_q.pop_front());
            chk("frame_start_cyc", fall_edge, exp_t_q.pop_front());
          end
        end
      end
    end
    prev_sclk = sclk;
  end

  initial begin
    rst = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    @(negedge clk);
    do_reset();

    // single sample, expected frame 16'h3A5C
    step(1'b1, 12'hA5C);
    idle(PERIOD + 10);

    // six back-to-back samples into depth 4: sixth dropped, overflow sticks
    for (int i = 0; i < 6; i++) step(1'b1, 12'($urandom_range(0, 4095)));
    idle(5 * PERIOD + 10);

    // boundary values back to back
    step(1'b1, 12'h000);
    step(1'b1, 12'hFFF);
    idle(2 * PERIOD + 10);

    // reset after 8 bits shifted: frame aborted, nothing sent afterwards
    step(1'b1, 12'h5A5);
    step(1'b1, 12'h3C3);
    idle(1 + 16 * CLK_DIV);
    do_reset();
    idle(PERIOD + 20);

    // randomized traffic, occasional bursts that overrun the FIFO
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        for (int j = 0; j < 6; j++) step(1'b1, 12'($urandom_range(0, 4095)));
      end else begin
        step($urandom_range(0, 39) == 0, 12'($urandom_range(0, 4095)));
      end
    end

    // drain with a bounded wait
    for (int i = 0; i < 20 * PERIOD; i++) begin
      if (exp_q.size() == 0 && m_q.size() == 0 && !m_busy()) break;
      step(1'b0, 12'h000);
    end
    idle(5);
    chk("drain_exp_q", exp_q.size(), 0);
    chk("drain_model_fifo", m_q.size(), 0);
    chk("end_cs_n", cs_n, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
